// File: rtl/enemy_jump_if.sv
// Bundle between jump-decision logic, platform lookup and the enemy jump controller.
// The controller attaches as slave; the driving side (or a bench) attaches as master.
interface enemy_jump_if #(
    parameter int Y_W = 10
);
    logic           frame_tick;
    logic           jump_req;
    logic [Y_W-1:0] ground_y;
    logic           spawn;
    logic [Y_W-1:0] spawn_y;
    logic [Y_W-1:0] enemy_y;
    logic           airborne;
    logic           jump_start;
    logic           land;

    modport master (
        output frame_tick, jump_req, ground_y, spawn, spawn_y,
        input  enemy_y, airborne, jump_start, land
    );

    modport slave (
        input  frame_tick, jump_req, ground_y, spawn, spawn_y,
        output enemy_y, airborne, jump_start, land
    );
endinterface

// File: rtl/enemy_jump_ctrl.sv
// Enemy vertical motion: frame-rate ballistic jump arc (rise, apex, fall) landing on
// the floor height supplied each frame. Screen y grows downward.
module enemy_jump_ctrl #(
    parameter int Y_W      = 10,
    parameter int JUMP_V0  = 8,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 8,
    parameter int COOLDOWN = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    enemy_jump_if.slave  bus
);
    localparam int VMAX  = (JUMP_V0 > MAX_FALL) ? JUMP_V0 : MAX_FALL;
    localparam int VEL_W = $clog2(VMAX + 1) + 1;
    localparam int CD_W  = $clog2(COOLDOWN + 2);

    localparam logic [VEL_W:0]   GRAV_X  = (VEL_W + 1)'(GRAVITY);
    localparam logic [VEL_W:0]   MAXF_X  = (VEL_W + 1)'(MAX_FALL);
    localparam logic [VEL_W-1:0] GRAV_V  = VEL_W'(GRAVITY);
    localparam logic [VEL_W-1:0] MAXF_V  = VEL_W'(MAX_FALL);
    localparam logic [VEL_W-1:0] V0_V    = VEL_W'(JUMP_V0);
    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(COOLDOWN);
    localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1);

    typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

    state_t          r_state, w_state_nx;
    logic [Y_W-1:0]  r_y, w_y_nx;
    logic [VEL_W-1:0] r_vel, w_vel_nx;
    logic [CD_W-1:0] r_cd, w_cd_nx;
    logic            r_js, w_js_nx;
    logic            r_land, w_land_nx;

    logic [VEL_W:0]   w_vsum;
    logic [VEL_W-1:0] w_vfall;
    logic [VEL_W-1:0] w_vrise;
    logic [Y_W:0]     w_ysum;
    logic [Y_W-1:0]   w_vel_y;

    // Fall speed saturates at terminal velocity; the landing sum is one bit wider so it never wraps.
    assign w_vsum  = {1'b0, r_vel} + GRAV_X;
    assign w_vfall = (w_vsum > MAXF_X) ? MAXF_V : w_vsum[VEL_W-1:0];
    assign w_ysum  = {1'b0, r_y} + {{(Y_W + 1 - VEL_W){1'b0}}, w_vfall};
    assign w_vel_y = {{(Y_W - VEL_W){1'b0}}, r_vel};
    assign w_vrise = (r_vel > GRAV_V) ? (r_vel - GRAV_V) : '0;

    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_vel_nx   = r_vel;
        w_cd_nx    = r_cd;
        w_js_nx    = 1'b0;
        w_land_nx  = 1'b0;
        if (bus.spawn) begin
            w_state_nx = GROUNDED;
            w_y_nx     = bus.spawn_y;
            w_vel_nx   = '0;
            w_cd_nx    = '0;
        end else if (bus.frame_tick) begin
            unique case (r_state)
                GROUNDED: begin
                    if (bus.ground_y > r_y) begin
                        w_state_nx = FALLING;
                        w_vel_nx   = '0;
                    end else if (bus.jump_req && (r_cd == '0)) begin
                        w_state_nx = RISING;
                        w_vel_nx   = V0_V;
                        w_js_nx    = 1'b1;
                    end else begin
                        w_y_nx = bus.ground_y;
                        if (r_cd != '0) w_cd_nx = r_cd - CD_ONE;
                    end
                end
                RISING: begin
                    // Not enough headroom for this frame's rise: pin to the top of screen.
                    if (r_y < w_vel_y) begin
                        w_y_nx     = '0;
                        w_vel_nx   = '0;
                        w_state_nx = FALLING;
                    end else begin
                        w_y_nx   = r_y - w_vel_y;
                        w_vel_nx = w_vrise;
                        if (w_vrise == '0) w_state_nx = FALLING;
                    end
                end
                FALLING: begin
                    if (w_ysum >= {1'b0, bus.ground_y}) begin
                        w_y_nx     = bus.ground_y;
                        w_vel_nx   = '0;
                        w_state_nx = GROUNDED;
                        w_land_nx  = 1'b1;
                        w_cd_nx    = CD_INIT;
                    end else begin
                        w_y_nx   = w_ysum[Y_W-1:0];
                        w_vel_nx = w_vfall;
                    end
                end
                default: w_state_nx = GROUNDED;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= GROUNDED;
            r_y     <= '0;
            r_vel   <= '0;
            r_cd    <= '0;
            r_js    <= 1'b0;
            r_land  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_y     <= w_y_nx;
            r_vel   <= w_vel_nx;
            r_cd    <= w_cd_nx;
            r_js    <= w_js_nx;
            r_land  <= w_land_nx;
        end
    end

    assign bus.enemy_y    = r_y;
    assign bus.airborne   = (r_state != GROUNDED);
    assign bus.jump_start = r_js;
    assign bus.land       = r_land;
endmodule

// File: doc/enemy_jump_ctrl.md
# enemy_jump_ctrl

Executes enemy jumps requested by the combinational jump-decision logic. Owns the enemy's vertical position and runs a frame-rate ballistic arc: rise, apex, fall, land on the floor height supplied by the platform lookup. Sits between the jump-decision block and the enemy sprite/position register feeding the draw logic. Screen y grows downward.

## Interface
- Y_W, 10, width of the y coordinate and the floor height
- JUMP_V0, 8, initial upward speed in px/frame
- GRAVITY, 1, speed change per frame in px/frame
- MAX_FALL, 8, terminal downward speed in px/frame
- COOLDOWN, 4, grounded frames after landing before a new jump is accepted
- Clk  in  1  system clock; the only clock
- Reset_n  in  1  reset, asynchronous assert, active-low
- frame_tick  in  1  one-Clk pulse per video frame; all motion advances only on this
- jump_req  in  1  level from the jump-decision logic; sampled only on frame_tick
- ground_y  in  Y_W  floor y directly beneath the enemy this frame
- spawn  in  1  load spawn_y, force grounded; priority over everything except reset
- spawn_y  in  Y_W  spawn position
- enemy_y  out  Y_W  registered vertical position
- airborne  out  1  high in RISING or FALLING
- jump_start  out  1  one-Clk pulse on the tick a jump is accepted
- land  out  1  one-Clk pulse on the tick the enemy lands

## Operation
- State register: GROUNDED, RISING, FALLING. Internal vel (unsigned, width ≥ clog2(max(JUMP_V0, MAX_FALL))+1) and cooldown counter.
- Reset (async, Reset_n=0): state GROUNDED, enemy_y=0, vel=0, cooldown=0, all pulses 0.
- spawn=1 on any Clk edge (tick or not): enemy_y=spawn_y, GROUNDED, vel=0, cooldown=0, no pulses.
- Nothing changes on cycles without frame_tick (except spawn).
- GROUNDED on tick:
  - ground_y > enemy_y (walked off a ledge): FALLING, vel=0; no jump accepted this tick.
  - else if jump_req and cooldown==0: RISING, vel=JUMP_V0, jump_start=1. y does not move this tick.
  - else enemy_y=ground_y (tracks raised floor), cooldown decrements if nonzero.
- RISING on tick: if enemy_y < vel then enemy_y=0, vel=0, FALLING (ceiling clamp); else enemy_y -= vel, vel -= GRAVITY (saturate at 0); if new vel==0 go FALLING.
- FALLING on tick: v' = min(vel+GRAVITY, MAX_FALL); if enemy_y+v' ≥ ground_y then enemy_y=ground_y, vel=0, GROUNDED, land=1, cooldown=COOLDOWN; else enemy_y += v', vel=v'. Sum computed Y_W+1 bits wide; no wrap.
- jump_req while airborne or during cooldown is ignored, not queued.
- ground_y may change every frame; the landing compare uses the value present on the tick.

## Timing
- All outputs registered; effects of a tick are visible the Clk after the frame_tick cycle.
- jump_start and land are high exactly one Clk, coincident with the state update; never both in the same cycle.
- Full arc with defaults from a flat floor: 1 accept tick + 8 rise ticks + 8 fall ticks; land on the 17th tick after acceptance begins.
- Reset mid-arc: immediate return to reset values, no land pulse.
- spawn and frame_tick in the same cycle: spawn wins, tick discarded.

## Test plan
- Reset then spawn_y=400, ground_y=400, jump_req=1 on tick -> jump_start pulse, airborne=1, y=400; next 8 ticks y=392,385,379,374,370,367,365,364; state FALLING.
- Continue same arc -> y=365,367,370,374,379,385,392, then 400 with land pulse, airborne=0, cooldown=4.
- jump_req held high after landing -> no jump_start for 4 ticks; jump_start on the 5th tick.
- Grounded at y=300, ground_y changes to 340 -> FALLING; y=301,303,306,310,315,321,328,336, then 340 with land pulse (ninth tick clamps to floor).
- Rising from y=20 with V0=8 -> 12, 5, then clamp to 0 and FALLING on third tick.
- Reset_n low mid-rise, and spawn asserted mid-fall with spawn_y=200 -> outputs at reset values / y=200 GROUNDED immediately, no land pulse in either case.
